// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, pointer-width helper and output-buffer state encoding
// for the small synchronous FIFO.
package fifo_pkg;
   localparam int AW_DEF = 2;
   localparam int DW_DEF = 8;
   localparam int PW_DEF = AW_DEF + 1;
   typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} buf_st_t;
   function automatic int ptr_w(input int aw);
      return aw + 1;
   endfunction
endpackage

// File: rtl/ptr_eq_cmp.sv
// ptr_eq_cmp: unsigned W-bit equality / greater-than comparator built as a
// bitwise compare chain, the higher differing bit overriding lower ones.
module ptr_eq_cmp #(
   parameter int W = fifo_pkg::PW_DEF
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_eq,
   output logic         o_gt
);
   always_comb begin
      o_eq = 1'b1;
      o_gt = 1'b0;
      for (int i = 0; i < W; i++) begin
         o_gt = (i_a[i] & ~i_b[i]) | (~(i_a[i] ^ i_b[i]) & o_gt);
         o_eq = o_eq & ~(i_a[i] ^ i_b[i]);
      end
   end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side FIFO controller with a 2-entry registered output buffer.
// Define FIFO_RD_ERR_EN to enable the sticky overrun flag o_err.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [AW:0]   i_wr_ptr,
   output logic          o_mem_re,
   output logic [AW-1:0] o_mem_raddr,
   input  logic [DW-1:0] i_mem_rdata,
   output logic [DW-1:0] o_dout,
   output logic          o_dout_vld,
   input  logic          i_dout_rdy,
   output logic [AW:0]   o_rd_ptr,
   output logic          o_empty,
   output logic [AW:0]   o_level,
   output logic          o_err
);
   localparam int PW = ptr_w(AW);
   logic [PW-1:0] r_rd_ptr;
   logic          r_pend;
   logic          r_vld;
   buf_st_t       r_state;
   logic [DW-1:0] r_buf0;
   logic [DW-1:0] r_buf1;
   logic [PW-1:0] w_level;
   logic          w_lvl_eq;
   logic          w_lvl_gt;
   logic          w_pop;
   logic [1:0]    w_occ;
   assign w_level     = i_wr_ptr - r_rd_ptr;
   assign w_pop       = r_vld & i_dout_rdy;
   // words held or arriving next cycle once this cycle's pop has left
   assign w_occ       = r_state + {1'b0, r_pend} - {1'b0, w_pop};
   assign o_mem_re    = i_rst_n & w_lvl_gt & ~w_occ[1];
   assign o_mem_raddr = r_rd_ptr[AW-1:0];
   assign o_rd_ptr    = r_rd_ptr;
   assign o_level     = w_level;
   assign o_empty     = w_lvl_eq;
   assign o_dout      = r_buf0;
   assign o_dout_vld  = r_vld;
   ptr_eq_cmp #(.W(PW)) u_empty (
      .i_a  (w_level),
      .i_b  ({PW{1'b0}}),
      .o_eq (w_lvl_eq),
      .o_gt (w_lvl_gt)
   );
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr <= '0;
         r_pend   <= 1'b0;
         r_vld    <= 1'b0;
         r_state  <= S0;
         r_buf0   <= '0;
         r_buf1   <= '0;
      end else begin
         if (o_mem_re) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_pend <= o_mem_re;
         case (r_state)
            S0: if (r_pend) begin
               r_buf0  <= i_mem_rdata;
               r_state <= S1;
               r_vld   <= 1'b1;
            end
            S1: if (w_pop && r_pend) begin
               r_buf0 <= i_mem_rdata;
            end else if (w_pop) begin
               r_state <= S0;
               r_vld   <= 1'b0;
            end else if (r_pend) begin
               r_buf1  <= i_mem_rdata;
               r_state <= S2;
            end
            S2: if (w_pop) begin
               r_buf0  <= r_buf1;
               r_state <= S1;
            end
            default: begin
               r_state <= S0;
               r_vld   <= 1'b0;
            end
         endcase
      end
   end
`ifdef FIFO_RD_ERR_EN
   logic w_ovr_eq;
   logic w_ovr_gt;
   logic r_err;
   // level > DEPTH  <=>  level >= DEPTH + 1
   ptr_eq_cmp #(.W(PW)) u_ovr (
      .i_a  (w_level),
      .i_b  (PW'((1 << AW) + 1)),
      .o_eq (w_ovr_eq),
      .o_gt (w_ovr_gt)
   );
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_err <= 1'b0;
      else if (w_ovr_eq || w_ovr_gt) r_err <= 1'b1;
   end
   assign o_err = r_err;
`else
   assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: vector table plus scoreboard for fifo_rd_ctrl (AW=2, DW=8).
module tb_fifo_rd_ctrl;
   typedef struct {
      logic [2:0] wr;
      logic       rdy;
      logic       re;
      logic       vld;
      logic [2:0] rd;
      logic       empty;
      logic [2:0] lvl;
   } vec_t;
`ifdef FIFO_RD_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] wr_ptr = '0;
   logic       mem_re;
   logic [1:0] raddr;
   logic [7:0] rdata = '0;
   logic [7:0] dout;
   logic       vld;
   logic       rdy = 1'b0;
   logic [2:0] rd_ptr;
   logic       empty;
   logic [2:0] level;
   logic       err;
   logic [7:0] mem [4];
   logic [7:0] q [$];
   logic [7:0] seq = 8'h30;
   logic [7:0] w2;
   logic [7:0] sb_exp;
   logic [2:0] cur = '0;
   logic [2:0] prv_rd = '0;
   logic       wrapped = 1'b0;
   bit         sb_en = 1'b1;
   int         n_cmp = 0;
   int         n_err = 0;
   vec_t       tbl [17];
   always #5 clk = ~clk;
   fifo_rd_ctrl #(.AW(2), .DW(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_wr_ptr    (wr_ptr),
      .o_mem_re    (mem_re),
      .o_mem_raddr (raddr),
      .i_mem_rdata (rdata),
      .o_dout      (dout),
      .o_dout_vld  (vld),
      .i_dout_rdy  (rdy),
      .o_rd_ptr    (rd_ptr),
      .o_empty     (empty),
      .o_level     (level),
      .o_err       (err)
   );
   always @(posedge clk) if (mem_re) rdata <= mem[raddr];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic put(input logic [2:0] to);
      while (cur != to) begin
         mem[cur[1:0]] = seq;
         q.push_back(seq);
         seq++;
         cur++;
      end
   endtask
   task automatic drive(input logic [2:0] to, input logic r);
      @(negedge clk);
      put(to);
      wr_ptr = to;
      rdy = r;
      #1;
   endtask
   task automatic drain(input string nm);
      int k = 0;
      while ((q.size() != 0 || vld) && k < 30) begin
         drive(cur, 1'b1);
         k++;
      end
      chk(nm, k < 30, 1);
   endtask
   always @(negedge clk) begin
      #2;
      if (rst_n && sb_en && vld && rdy) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_pop: dout=%0h popped, no word expected", dout);
         end else begin
            sb_exp = q.pop_front();
            chk("sb_data", dout, sb_exp);
         end
      end
   end
   always @(negedge clk) begin
      if (prv_rd == 3'd7 && rd_ptr == 3'd0) wrapped = 1'b1;
      prv_rd = rd_ptr;
   end
   initial begin
      //          wr    rdy   re    vld   rd    empty lvl
      tbl[0]  = '{3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd1};
      tbl[1]  = '{3'd2, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 3'd1};
      tbl[2]  = '{3'd3, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 3'd1};
      tbl[3]  = '{3'd4, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd1};
      tbl[4]  = '{3'd4, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 3'd0};
      tbl[5]  = '{3'd4, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 3'd0};
      tbl[6]  = '{3'd4, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 3'd0};
      tbl[7]  = '{3'd0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4};
      tbl[8]  = '{3'd0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 3'd3};
      tbl[9]  = '{3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 3'd2};
      tbl[10] = '{3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 3'd2};
      tbl[11] = '{3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 3'd2};
      tbl[12] = '{3'd0, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 3'd2};
      tbl[13] = '{3'd0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 3'd1};
      tbl[14] = '{3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0};
      tbl[15] = '{3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0};
      tbl[16] = '{3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0};
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rst%0d_empty", i), empty, 1);
         chk($sformatf("rst%0d_re", i), mem_re, 0);
         chk($sformatf("rst%0d_vld", i), vld, 0);
         chk($sformatf("rst%0d_rd", i), rd_ptr, 0);
      end
      chk("rst_dout", dout, 0);
      chk("rst_err", err, 0);
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].wr, tbl[i].rdy);
         chk($sformatf("t%0d_re", i), mem_re, tbl[i].re);
         chk($sformatf("t%0d_vld", i), vld, tbl[i].vld);
         chk($sformatf("t%0d_rd", i), rd_ptr, tbl[i].rd);
         chk($sformatf("t%0d_empty", i), empty, tbl[i].empty);
         chk($sformatf("t%0d_lvl", i), level, tbl[i].lvl);
         if (!tbl[i].rdy && vld) chk($sformatf("t%0d_hold", i), dout, q[0]);
      end
      // pop and capture together while holding one word
      drive(3'd1, 1'b0);
      chk("pc_re0", mem_re, 1);
      drive(3'd1, 1'b0);
      chk("pc_re1", mem_re, 0);
      drive(3'd2, 1'b0);
      w2 = seq - 8'd1;
      chk("pc_vld2", vld, 1);
      chk("pc_re2", mem_re, 1);
      drive(3'd2, 1'b1);
      chk("pc_vld3", vld, 1);
      chk("pc_dout3", dout, w2 - 8'd1);
      drive(3'd2, 1'b0);
      chk("pc_vld4", vld, 1);
      chk("pc_dout4", dout, w2);
      drive(3'd2, 1'b1);
      drive(3'd2, 1'b1);
      chk("pc_vld6", vld, 0);
      // wrap: 12 words total with the read pointer crossing 7 -> 0
      for (int i = 0; i < 3; i++) drive(cur + 3'd1, 1'b1);
      drain("wr_drain0");
      chk("wr_rd5", rd_ptr, 5);
      wrapped = 1'b0;
      drive(3'd1, 1'b1);
      chk("wr_empty", empty, 0);
      chk("wr_rd", rd_ptr, 5);
      chk("wr_lvl4", level, 4);
      chk("wr_re", mem_re, 1);
      drain("wr_drain1");
      chk("wr_wrapped", wrapped, 1);
      chk("wr_rd1", rd_ptr, 1);
      for (int i = 0; i < 5; i++) drive(cur + 3'd1, 1'b1);
      drain("wr_drain2");
      chk("wr_rd6", rd_ptr, 6);
      chk("wr_empty_end", empty, 1);
      // asynchronous reset while a word is buffered and storage is non-empty
      drive(3'd0, 1'b0);
      drive(3'd0, 1'b0);
      drive(3'd0, 1'b0);
      drive(3'd1, 1'b0);
      chk("mr_vld_pre", vld, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_re", mem_re, 0);
      chk("mr_vld", vld, 0);
      chk("mr_rd", rd_ptr, 0);
      chk("mr_dout", dout, 0);
      chk("mr_err", err, 0);
      q.delete();
      sb_en = 1'b0;
      wr_ptr = '0;
      cur = '0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(3'd0, 1'b0);
      // writer overruns the reader
      @(negedge clk);
      wr_ptr = 3'd5;
      cur = 3'd5;
      #1;
      chk("ovr_lvl5", level, 5);
      chk("ovr_err0", err, 0);
      @(negedge clk);
      #1;
      chk("ovr_err1", err, EXP_ERR);
      repeat (3) drive(3'd5, 1'b0);
      @(negedge clk);
      wr_ptr = 3'd2;
      cur = 3'd2;
      #1;
      chk("ovr_lvl0", level, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("ovr_sticky%0d", i), err, EXP_ERR);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
